// File: rtl/rr_sel4_pkg.sv
// rr_sel4_pkg: shared types and helpers for the rr_sel4 round-robin select
// generator.
//   state_t : arbiter state (IDLE, GRANT)
//   NCH     : number of request channels
//   ch2sel  : converts a natural channel index into the swapped-bit select
//             that the 4:1 mux decoder expects.
package rr_sel4_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The mux decoder treats s[0] as its MSB, so the index bits are swapped.
  function automatic logic [1:0] ch2sel(input logic [1:0] ch);
    return {ch[0], ch[1]};
  endfunction

endpackage

// File: rtl/rr_sel4_if.sv
// rr_sel4_if: request/select bundle between the requesters, the arbiter and
// the mux.
//   req   : per-channel request lines (bit k = channel k)
//   s     : mux select, swapped-bit encoding
//   gnt   : one-hot grant, zero when idle
//   valid : a grant is active; qualifies the mux output
//   ch    : granted channel index, natural binary
// Modports: master = requester side (drives req), slave = arbiter side.
interface rr_sel4_if;
  logic [3:0] req;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       valid;
  logic [1:0] ch;

  modport master (output req, input s, input gnt, input valid, input ch);
  modport slave  (input req, output s, output gnt, output valid, output ch);
endinterface

// File: rtl/rr_sel4_pick4.sv
// rr_pick4: combinational rotating-priority picker for four channels.
//   req      : request lines
//   ptr      : channel searched first; order is ptr, ptr+1, ptr+2, ptr+3
//   excl_en  : when set, channel excl_idx is not eligible
//   excl_idx : channel to exclude
//   hit      : at least one eligible request
//   idx      : first eligible channel in search order (0 when no hit)
module rr_pick4
  import rr_sel4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       hit,
  output logic [1:0] idx
);

  logic [NCH-1:0] elig;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
    assign elig[gi] = req[gi] && !(excl_en && (excl_idx == 2'(gi)));
  end

  // Walk from the farthest offset back to ptr so the nearest eligible
  // channel is the one left in idx.
  always_comb begin
    logic [1:0] j;
    hit = 1'b0;
    idx = 2'd0;
    j   = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = ptr + 2'(i);
      if (elig[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/rr_sel4.sv
// rr_sel4: round-robin select generator for the 4:1 tristate mux.
// Grants one requesting channel at a time with rotating priority and holds
// the grant while that channel keeps requesting. All outputs are registered
// and reflect the state entered at the most recent clock edge.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_sel4_if.slave (req in; s, gnt, valid, ch out)
// Parameters: HOLD_MAX (1..255) grant beat limit, CW counter width.
// Optional build macro RR_SEL4_TIMEOUT_EN: adds the hold counter so a channel
// is forced off after HOLD_MAX cycles when another channel is requesting.
module rr_sel4
  import rr_sel4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input  logic     clk,
  input  logic     rst,
  rr_sel4_if.slave bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255 || HOLD_MAX >= (2 ** CW)) begin : g_bad_cfg
    $error("rr_sel4: HOLD_MAX must be 1..255 and below 2**CW");
  end

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] cur_reg, cur_next;
  logic [1:0] s_reg;
  logic [3:0] gnt_reg;
  logic       valid_reg;
  logic [1:0] ch_reg;

  logic       drop;
  logic       timeout;
  logic       others;
  logic [1:0] pick_ptr;
  logic       pick_hit;
  logic [1:0] pick_idx;

  assign drop   = !bus.req[cur_reg];
  assign others = |(bus.req & ~(4'b0001 << cur_reg));

`ifdef RR_SEL4_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  logic [CW-1:0] cnt_reg, cnt_next;
  assign timeout = (cnt_reg >= HOLD_LIM) && others;
`else
  assign timeout = 1'b0;
`endif

  // In GRANT the picker already sees the post-handover search order, so a
  // grant ending at this edge re-arbitrates without a dead cycle.
  assign pick_ptr = (state_reg == GRANT) ? 2'(cur_reg + 2'd1) : ptr_reg;

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .excl_en (timeout),
    .excl_idx(cur_reg),
    .hit     (pick_hit),
    .idx     (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cur_next   = cur_reg;
`ifdef RR_SEL4_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_hit) begin
          state_next = GRANT;
          cur_next   = pick_idx;
`ifdef RR_SEL4_TIMEOUT_EN
          cnt_next   = CW'(1);
`endif
        end
      end
      GRANT: begin
        if (drop || timeout) begin
          ptr_next = 2'(cur_reg + 2'd1);
          if (pick_hit) begin
            cur_next = pick_idx;
`ifdef RR_SEL4_TIMEOUT_EN
            cnt_next = CW'(1);
`endif
          end else begin
            state_next = IDLE;
          end
`ifdef RR_SEL4_TIMEOUT_EN
        end else if (cnt_reg < HOLD_LIM) begin
          // Saturates at HOLD_LIM while the channel is the only requester.
          cnt_next = cnt_reg + CW'(1);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      cur_reg   <= 2'd0;
      s_reg     <= 2'b00;
      gnt_reg   <= 4'b0000;
      valid_reg <= 1'b0;
      ch_reg    <= 2'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cur_reg   <= cur_next;
      valid_reg <= (state_next == GRANT);
      gnt_reg   <= (state_next == GRANT) ? (4'b0001 << cur_next) : 4'b0000;
      // s and ch keep their last value while idle; valid marks them stale.
      if (state_next == GRANT) begin
        s_reg  <= ch2sel(cur_next);
        ch_reg <= cur_next;
      end
    end
  end

`ifdef RR_SEL4_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end
`endif

  assign bus.s     = s_reg;
  assign bus.gnt   = gnt_reg;
  assign bus.valid = valid_reg;
  assign bus.ch    = ch_reg;

endmodule

// File: doc/rr_sel4.md
# rr_sel4

Round-robin select generator driving the 2-bit select of the 4:1 tristate mux (`mux4_1_tri`). It watches four channel request lines, grants one channel at a time with rotating priority, and holds the grant while that channel keeps requesting, optionally up to a beat limit. It emits the mux select in the encoding the mux decoder expects, a one-hot grant back to the requesters, and a `valid` qualifier so consumers ignore the mux output while nothing is granted.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles per channel when the timeout is compiled in; legal range 1..255.
- `CW`, default 8: width of the hold counter; must satisfy `HOLD_MAX < 2**CW`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-channel request; bit k is channel k.
- `s`  out  2  select to the mux, in swapped-bit encoding.
- `gnt`  out  4  one-hot grant; all zero when idle.
- `valid`  out  1  high while a grant is active; qualifies mux output `y`.
- `ch`  out  2  granted channel index in natural binary, for debug and test.

## Operation
- Two states:
  - IDLE: `gnt=0`, `valid=0`.
  - GRANT: exactly one `gnt` bit set, `valid=1`.
- Priority pointer `ptr` (2 bits) is the channel searched first. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4.
- IDLE -> GRANT when `req != 0`. The first requesting channel in search order becomes `cur`. The hold counter loads 1.
- In GRANT, the grant ends at the next edge when either:
  - `req[cur]` drops, or
  - the timeout is compiled in, the hold count reaches `HOLD_MAX`, and another channel is requesting.
- When the grant ends:
  - `ptr` becomes `cur+1` mod 4.
  - The arbiter re-arbitrates in that same edge using the new search order, excluding `cur` only on timeout.
  - If any eligible request exists, it stays in GRANT with the new `cur` and the counter at 1. Otherwise it goes to IDLE.
- Timeout with no other requester: the grant continues and the counter saturates at `HOLD_MAX`.
- Select encoding: the mux decoder takes `s[0]` as its MSB, so `s = {cur[0], cur[1]}`.
  - Channel 0 -> 2'b00, channel 1 -> 2'b10, channel 2 -> 2'b01, channel 3 -> 2'b11.
- In IDLE, `s` holds its last value; only `valid` marks it stale.
- Requests arriving mid-grant never preempt, except through the timeout rule.

## Timing
- All outputs are registered. The grant appears one cycle after the edge that samples `req`.
- While `rst=1` at an edge, the next state is:
  - state IDLE, `ptr=0`, `cur=0`, counter 0;
  - `s=2'b00`, `gnt=4'b0000`, `valid=0`, `ch=0`.
- Reset mid-grant drops the grant at that edge. The first arbitration after reset starts from channel 0.
- Handover: `req[cur]` low at edge n means the new grant is visible after edge n. There are no dead cycles between back-to-back grants.
- Same-edge `req` changes: the dropping channel loses the grant, and any other request sampled in that cycle competes at the same edge.
- Wrap-around: `ptr` after channel 3 is channel 0.

## Configuration
- `RR_SEL4_TIMEOUT_EN` defined:
  - The hold counter and `HOLD_MAX` limit are built.
  - A channel is forced off after `HOLD_MAX` cycles if another channel is requesting.
- Not defined:
  - No counter is built and `HOLD_MAX` is ignored.
  - A grant lasts until its request drops, so one channel can starve the others indefinitely.

## Structure
- Shared package `rr_sel4_pkg` holds:
  - state enum `{IDLE, GRANT}`;
  - function `ch2sel(ch)` returning `{ch[0],ch[1]}`;
  - localparam `NCH = 4`.
- One sub-module, `rr_pick4`: combinational rotating-priority picker.
  - Inputs: `req`, `ptr`, `excl_en`, `excl_idx`.
  - Outputs: `hit`, `idx`.
- The top level holds the state register, `ptr`, `cur`, the counter, and the output registers.

## Test plan
- Reset then idle: hold `rst=1` for 2 cycles, then `req=0` -> `valid=0`, `gnt=0`, `s=2'b00` throughout.
- Single channel: `req=4'b0010` -> after 1 cycle `gnt=4'b0010`, `ch=1`, `s=2'b10`, `valid=1`. Drop `req` -> next cycle `valid=0`, `s` stays 2'b10.
- Rotation: `req=4'b1111`, each granted channel drops for one cycle on handover -> grants in order ch0, ch1, ch2, ch3, ch0 with `s` = 00, 10, 01, 11, 00 and no idle cycles.
- Timeout (macro on, `HOLD_MAX=3`):
  - `req=4'b0101` held -> ch0 for 3 cycles, then ch2 for 3 cycles, then ch0.
  - `req=4'b0001` held -> ch0 granted indefinitely.
- Macro off, same `req=4'b0101` held -> ch0 granted indefinitely, ch2 never granted.
- Reset mid-grant: during a ch3 grant assert `rst` for 1 cycle with `req=4'b1001` -> `valid` drops at the reset edge, then ch0 is granted, not ch3.
